// File: rtl/mac_vec_driver_if.sv
// Control/data bus between the dot-product sequencer and one MAC accumulator.
// The sequencer is the master: it owns clear, enable and both operands.
interface mac_vec_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      mac_clr;
  logic                      mac_en;
  logic [DATA_WIDTH-1:0]     mac_ain;
  logic [DATA_WIDTH-1:0]     mac_bin;
  logic [3*DATA_WIDTH-1:0]   mac_cout;

  modport master (
    output mac_clr, mac_en, mac_ain, mac_bin,
    input  mac_cout
  );

  modport slave (
    input  mac_clr, mac_en, mac_ain, mac_bin,
    output mac_cout
  );
endinterface

// File: rtl/mac_vec_driver.sv
// Dot-product sequencer: holds two operand vectors, clears the MAC, streams
// VEC_LEN operand pairs into it and captures the accumulated result.
module mac_vec_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [3*DATA_WIDTH-1:0] result,
  output logic                    result_valid,
  mac_vec_driver_if.master        mac
);
  localparam int RES_W = 3 * DATA_WIDTH;
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_CAPTURE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clr_q, clr_d;
  logic                en_q, en_d;

  logic [DATA_WIDTH-1:0] a_q [VEC_LEN];
  logic [DATA_WIDTH-1:0] b_q [VEC_LEN];
  logic [DATA_WIDTH-1:0] a_rd, b_rd;

  // Operand files: writable only while IDLE; addresses past VEC_LEN match no element.
  generate
    for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_elem
      logic                  hit;
      logic [DATA_WIDTH-1:0] a_d, b_d;

      assign hit = wr_en && (state_q == S_IDLE) && (wr_addr == ADDR_W'(gi));

      always_comb begin
        a_d = a_q[gi];
        b_d = b_q[gi];
        if (hit && !wr_sel) a_d = wr_data;
        if (hit &&  wr_sel) b_d = wr_data;
      end

      always_ff @(posedge clk) begin
        a_q[gi] <= a_d;
        b_q[gi] <= b_d;
      end
    end
  endgenerate

  always_comb begin
    a_rd = '0;
    b_rd = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (idx_q == ADDR_W'(i)) begin
        a_rd = a_q[i];
        b_rd = b_q[i];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_CLEAR;
          result_valid_d = 1'b0;
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        result_d       = mac.mac_cout;
        result_valid_d = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Control outputs are registered copies of the next-state decode.
    busy_d = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLEAR);
    en_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      clr_q          <= 1'b0;
      en_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      clr_q          <= clr_d;
      en_q           <= en_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign mac.mac_clr  = clr_q;
  assign mac.mac_en   = en_q;
  assign mac.mac_ain  = en_q ? a_rd : '0;
  assign mac.mac_bin  = en_q ? b_rd : '0;
endmodule

// File: tb/tb_mac_vec_driver.sv
// Bench for mac_vec_driver: directed runs on an 8-element and a 1-element
// instance, each driving a behavioural MAC; a monitor scores every done pulse.
module tb_mac_vec_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] res;
    int          scyc;
  } exp_t;
  exp_t sb[$];
  exp_t sb2[$];
  exp_t e1, e2;

  // DUT 1: default 8-element configuration
  logic        wr_en = 0, wr_sel = 0, start = 0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        busy, done, result_valid;
  logic [23:0] result;
  mac_vec_driver_if #(.DATA_WIDTH(8)) m1 ();

  mac_vec_driver #(.DATA_WIDTH(8), .VEC_LEN(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid), .mac(m1)
  );

  logic [23:0] acc1 = '0;
  always @(posedge clk)
    if (m1.mac_clr) acc1 <= '0;
    else if (m1.mac_en) acc1 <= acc1 + 24'(m1.mac_ain) * 24'(m1.mac_bin);
  assign m1.mac_cout = acc1;

  // DUT 2: single-element configuration
  logic        wr2_en = 0, wr2_sel = 0, start2 = 0;
  logic [0:0]  wr2_addr = '0;
  logic [7:0]  wr2_data = '0;
  logic        busy2, done2, result_valid2;
  logic [23:0] result2;
  mac_vec_driver_if #(.DATA_WIDTH(8)) m2 ();

  mac_vec_driver #(.DATA_WIDTH(8), .VEC_LEN(1), .ADDR_W(1)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr2_en), .wr_sel(wr2_sel), .wr_addr(wr2_addr),
    .wr_data(wr2_data), .start(start2), .busy(busy2), .done(done2), .result(result2),
    .result_valid(result_valid2), .mac(m2)
  );

  logic [23:0] acc2 = '0;
  always @(posedge clk)
    if (m2.mac_clr) acc2 <= '0;
    else if (m2.mac_en) acc2 <= acc2 + 24'(m2.mac_ain) * 24'(m2.mac_bin);
  assign m2.mac_cout = acc2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for DUT 1
  int en_cnt = 0;
  int clr_cyc = -1;
  always @(negedge clk) begin
    if (rst) begin
      en_cnt = 0;
    end else begin
      if (m1.mac_clr) begin
        clr_cyc = cyc;
        en_cnt  = 0;
      end
      if (m1.mac_en) en_cnt++;
      else check("ab_zero_outside_run", 64'({m1.mac_ain, m1.mac_bin}), '0);
      if (busy) check("rv_low_while_busy", 64'(result_valid), '0);
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done with result %0d, expected no done (cycle %0d)", result, cyc);
        end else begin
          e1 = sb.pop_front();
          $display("run done: result=%0d expected=%0d latency=%0d mac_en_cycles=%0d",
                   result, e1.res, cyc - e1.scyc, en_cnt);
          check("result", 64'(result), 64'(e1.res));
          check("result_valid_at_done", 64'(result_valid), 64'(1));
          check("busy_low_at_done", 64'(busy), '0);
          check("latency", 64'(cyc - e1.scyc), 64'(11));
          check("clr_in_cycle1", 64'(clr_cyc - e1.scyc), 64'(1));
          check("mac_en_cycles", 64'(en_cnt), 64'(8));
        end
      end
    end
  end

  // Monitor for DUT 2
  int en2_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      en2_cnt = 0;
    end else begin
      if (m2.mac_clr) en2_cnt = 0;
      if (m2.mac_en) en2_cnt++;
      if (done2) begin
        if (sb2.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done2: got done with result %0d, expected no done (cycle %0d)", result2, cyc);
        end else begin
          e2 = sb2.pop_front();
          $display("run2 done: result=%0d expected=%0d latency=%0d", result2, e2.res, cyc - e2.scyc);
          check("result2", 64'(result2), 64'(e2.res));
          check("latency2", 64'(cyc - e2.scyc), 64'(4));
          check("mac_en_cycles2", 64'(en2_cnt), 64'(1));
        end
      end
    end
  end

  task automatic chk_zero1(input string tag);
    check({tag, "_busy"}, 64'(busy), '0);
    check({tag, "_done"}, 64'(done), '0);
    check({tag, "_result"}, 64'(result), '0);
    check({tag, "_result_valid"}, 64'(result_valid), '0);
    check({tag, "_mac_clr"}, 64'(m1.mac_clr), '0);
    check({tag, "_mac_en"}, 64'(m1.mac_en), '0);
    check({tag, "_mac_ain"}, 64'(m1.mac_ain), '0);
    check({tag, "_mac_bin"}, 64'(m1.mac_bin), '0);
  endtask

  task automatic wr1(input logic sel, input int addr, input int data);
    wr_en = 1; wr_sel = sel; wr_addr = 3'(addr); wr_data = 8'(data);
    tick();
    wr_en = 0;
  endtask

  // One run on DUT 1. With poke set, a write and a start are issued mid-RUN and
  // a start is issued in the DONE cycle; all of them must be ignored.
  task automatic run1(input logic [23:0] exp, input bit poke);
    sb.push_back('{res: exp, scyc: cyc});
    start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    if (poke) begin
      wr_en = 1; wr_sel = 0; wr_addr = 3'd0; wr_data = 8'd99; start = 1;
    end
    tick();
    wr_en = 0; start = 0;
    repeat (7) tick();
    if (poke) start = 1;
    tick();
    start = 0;
    repeat (14) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk_zero1("reset");
    tick();

    for (int i = 0; i < 8; i++) wr1(1'b0, i, i + 1);
    for (int i = 0; i < 8; i++) wr1(1'b1, i, 1);
    run1(24'd36, 1'b1);
    run1(24'd36, 1'b0);

    // B[3]=10 against A[3]=4: 36 + 4*9
    wr1(1'b1, 3, 10);
    run1(24'd72, 1'b0);

    for (int i = 0; i < 8; i++) begin
      wr1(1'b0, i, 255);
      wr1(1'b1, i, 255);
    end
    run1(24'd520200, 1'b0);

    // Reset in RUN cycle 5 abandons the run with no done.
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk_zero1("mid_run_reset");
    repeat (15) tick();
    run1(24'd520200, 1'b0);

    // Write A[0]=0 in the same cycle as start: the run sees it, 7*255*255.
    wr_en = 1; wr_sel = 0; wr_addr = 3'd0; wr_data = 8'd0;
    run1(24'd455175, 1'b0);

    // Single-element instance; the write to address 1 is out of range.
    wr2_en = 1; wr2_sel = 0; wr2_addr = 1'b0; wr2_data = 8'd7; tick();
    wr2_sel = 1; wr2_data = 8'd9; tick();
    wr2_sel = 0; wr2_addr = 1'b1; wr2_data = 8'd5; tick();
    wr2_en = 0;
    sb2.push_back('{res: 24'd63, scyc: cyc});
    start2 = 1;
    tick();
    start2 = 0;
    repeat (10) tick();

    check("sb_drained", 64'(sb.size()), '0);
    check("sb2_drained", 64'(sb2.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
